// File: rtl/mac_loopback_param.sv
// Link-level loopback: moves RX MAC frames into internal TX FIFOs, dropping errored and runt frames.
// Define MAC_LB_STATS_EN to build the saturating good_cnt/drop_cnt statistics counters.
module mac_loopback_param #(
    parameter int LEN_W     = 11,
    parameter int DATA_AW   = 12,
    parameter int PTR_AW    = 5,
    parameter int STRIP_CRC = 1
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        rx_data_fifo_rd,
    input  logic [7:0]  rx_data_fifo_din,
    output logic        rx_ptr_fifo_rd,
    input  logic [15:0] rx_ptr_fifo_din,
    input  logic        rx_ptr_fifo_empty,
    input  logic        tx_data_fifo_rd,
    output logic [7:0]  tx_data_fifo_dout,
    input  logic        tx_ptr_fifo_rd,
    output logic [15:0] tx_ptr_fifo_dout,
    output logic        tx_ptr_fifo_empty,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, PTR, EVAL, WAIT, DATA, TAIL} state_t;

    localparam logic [DATA_AW:0] DDEPTH = {1'b1, {DATA_AW{1'b0}}};
    localparam logic [PTR_AW:0]  PDEPTH = {1'b1, {PTR_AW{1'b0}}};

    state_t             state_q;
    logic               rd_data_q, rd_ptr_q, rd_p1_q, good_q;
    logic [LEN_W-1:0]   cnt_q, widx_q, len_q, olen_q;

    logic [LEN_W-1:0]   len_in, olen_in, need;
    logic               good_in, fits, wr_en, pwr, pfull, good_evt, drop_evt;
    logic [DATA_AW:0]   dfree;

    logic [7:0]         dmem [2**DATA_AW];
    logic [DATA_AW-1:0] dwp_q, drp_q;
    logic [DATA_AW:0]   dcnt_q, dcnt_d;
    logic               drd_ok;
    logic [7:0]         dout_q;

    logic [LEN_W-1:0]   pmem [2**PTR_AW];
    logic [PTR_AW-1:0]  pwp_q, prp_q;
    logic [PTR_AW:0]    pcnt_q, pcnt_d;
    logic               prd_ok;
    logic [LEN_W-1:0]   pout_q;

    logic               unused_ptr_bits;

    assign unused_ptr_bits = ^rx_ptr_fifo_din;

    assign len_in  = rx_ptr_fifo_din[LEN_W-1:0];
    assign olen_in = (STRIP_CRC != 0) ? len_in - LEN_W'(4) : len_in;
    assign good_in = (rx_ptr_fifo_din[15:14] == 2'b00) &&
                     ((STRIP_CRC != 0) ? (32'(len_in) > 32'd4) : (len_in != '0));

    // Admission compares against the pointer on the bus in EVAL, against the latched length in WAIT.
    assign need  = (state_q == EVAL) ? olen_in : olen_q;
    assign dfree = DDEPTH - dcnt_q;
    assign fits  = dfree >= (DATA_AW+1)'(need);
    assign pfull = (pcnt_q == PDEPTH);

    assign wr_en    = rd_p1_q && good_q && (widx_q < olen_q);
    assign pwr      = (state_q == TAIL) && good_q;
    assign good_evt = pwr;
    assign drop_evt = ((state_q == EVAL) && (len_in == '0)) || ((state_q == TAIL) && !good_q);

    assign rx_data_fifo_rd = rd_data_q;
    assign rx_ptr_fifo_rd  = rd_ptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rd_data_q <= 1'b0;
            rd_ptr_q  <= 1'b0;
            good_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_ptr_fifo_empty && !pfull) begin
                        rd_ptr_q <= 1'b1;
                        state_q  <= PTR;
                    end
                end
                PTR: begin
                    rd_ptr_q <= 1'b0;
                    state_q  <= EVAL;
                end
                EVAL: begin
                    good_q <= good_in;
                    cnt_q  <= '0;
                    if (len_in == '0) begin
                        state_q <= IDLE;
                    end else if (good_in && !fits) begin
                        state_q <= WAIT;
                    end else begin
                        rd_data_q <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                WAIT: begin
                    if (fits) begin
                        rd_data_q <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        rd_data_q <= 1'b0;
                        state_q   <= TAIL;
                    end
                end
                TAIL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == EVAL) begin
            len_q  <= len_in;
            olen_q <= olen_in;
        end
    end

    // Read-data stage: the byte requested last cycle is on rx_data_fifo_din now.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_p1_q <= 1'b0;
            widx_q  <= '0;
        end else begin
            rd_p1_q <= rd_data_q;
            if (state_q == EVAL) begin
                widx_q <= '0;
            end else if (rd_p1_q) begin
                widx_q <= widx_q + LEN_W'(1);
            end
        end
    end

    assign drd_ok = tx_data_fifo_rd && (dcnt_q != '0);

    always_comb begin
        dcnt_d = dcnt_q;
        case ({wr_en, drd_ok})
            2'b10:   dcnt_d = dcnt_q + (DATA_AW+1)'(1);
            2'b01:   dcnt_d = dcnt_q - (DATA_AW+1)'(1);
            default: dcnt_d = dcnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            dmem[dwp_q] <= rx_data_fifo_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dwp_q  <= '0;
            drp_q  <= '0;
            dcnt_q <= '0;
            dout_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            if (wr_en) begin
                dwp_q <= dwp_q + DATA_AW'(1);
            end
            if (drd_ok) begin
                drp_q  <= drp_q + DATA_AW'(1);
                dout_q <= dmem[drp_q];
            end
        end
    end

    assign prd_ok = tx_ptr_fifo_rd && (pcnt_q != '0);

    always_comb begin
        pcnt_d = pcnt_q;
        case ({pwr, prd_ok})
            2'b10:   pcnt_d = pcnt_q + (PTR_AW+1)'(1);
            2'b01:   pcnt_d = pcnt_q - (PTR_AW+1)'(1);
            default: pcnt_d = pcnt_q;
        endcase
    end

    // The pointer is written on the same edge as the final stored byte, never ahead of it.
    always_ff @(posedge clk) begin
        if (pwr) begin
            pmem[pwp_q] <= olen_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwp_q  <= '0;
            prp_q  <= '0;
            pcnt_q <= '0;
            pout_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            if (pwr) begin
                pwp_q <= pwp_q + PTR_AW'(1);
            end
            if (prd_ok) begin
                prp_q  <= prp_q + PTR_AW'(1);
                pout_q <= pmem[prp_q];
            end
        end
    end

    assign tx_data_fifo_dout = dout_q;
    assign tx_ptr_fifo_dout  = 16'(pout_q);
    assign tx_ptr_fifo_empty = (pcnt_q == '0);

`ifdef MAC_LB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] good_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (good_evt) good_cnt_q <= sat_inc(good_cnt_q);
            if (drop_evt) drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign good_cnt = good_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_evt;
    assign unused_evt = good_evt ^ drop_evt;
    assign good_cnt   = '0;
    assign drop_cnt   = '0;
`endif

endmodule
